// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end (debouncer and gesture decoder).
//   gesture_state_t   : gesture decoder FSM encoding
//   *_3MHZ constants  : default timing parameters for the 3 MHz fabric clock
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT_GAP,
        PRESS2,
        LONG_HELD
    } gesture_state_t;

    localparam int unsigned LONG_CYCLES_3MHZ     = 3_000_000;  // 1 s
    localparam int unsigned GAP_CYCLES_3MHZ      = 750_000;    // 250 ms
    localparam int unsigned DEBOUNCE_CYCLES_3MHZ = 60_000;     // 20 ms

endpackage

// File: rtl/button_gesture_decoder.sv
// Classifies debounced button activity into short, double and long presses.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   btn_state    in   debounced button level, 1 = pressed, synchronous to clk
//   short_press  out  1-cycle pulse: single press released, no re-press within gap
//   double_press out  1-cycle pulse: second press released
//   long_press   out  1-cycle pulse: first press held for LONG_CYCLES
//   holding      out  level, high while a long press is being held
//   busy         out  level, high whenever a gesture is in progress
module button_gesture_decoder
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_3MHZ,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_3MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_state,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic holding,
    output logic busy
);

    localparam int unsigned MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    gesture_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             btn_prev;
    logic             rise;
    logic             short_d, double_d, long_d;

    assign rise = btn_state & ~btn_prev;

    // Release/re-press are tested before the counter threshold so that a
    // level change on the threshold cycle wins over the timeout.
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = PRESS1;
            end
            PRESS1: begin
                if (!btn_state) begin
                    state_d = WAIT_GAP;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end
            end
            WAIT_GAP: begin
                if (btn_state) begin
                    state_d = PRESS2;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (!btn_state) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end
            end
            LONG_HELD: begin
                if (!btn_state) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // btn_prev resets high so a button held through reset is not a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            btn_prev     <= 1'b1;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            holding      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q  <= state_d;
            btn_prev <= btn_state;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == PRESS1 || state_q == WAIT_GAP) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            short_press  <= short_d;
            double_press <= double_d;
            long_press   <= long_d;
            holding      <= (state_d == LONG_HELD);
            busy         <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder with LONG_CYCLES=20, GAP_CYCLES=8.
// Expected pulses (kind and edge number) are queued as stimulus is applied
// and matched against DUT pulses by a monitor sampling on the falling edge.
module tb_button_gesture_decoder;

    localparam int unsigned L = 20;
    localparam int unsigned G = 8;

    localparam int unsigned K_SHORT  = 1;
    localparam int unsigned K_DOUBLE = 2;
    localparam int unsigned K_LONG   = 3;

    typedef struct {
        int unsigned kind;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_state = 1'b0;
    logic short_press, double_press, long_press, holding, busy;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned p;

    button_gesture_decoder #(
        .LONG_CYCLES(L),
        .GAP_CYCLES (G)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_state   (btn_state),
        .short_press (short_press),
        .double_press(double_press),
        .long_press  (long_press),
        .holding     (holding),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: at a falling edge, cyc is the number of the last rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int unsigned obs, input int unsigned expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int unsigned kind, input int unsigned at_edge);
        exp_t e;
        e.kind = kind;
        e.cyc  = at_edge;
        exp_q.push_back(e);
    endtask

    // Pulse monitor / scoreboard consumer.
    always @(negedge clk) begin
        int unsigned kind;
        int unsigned npulse;
        exp_t e;
        npulse = int'(short_press) + int'(double_press) + int'(long_press);
        if (npulse != 0) begin
            kind = short_press ? K_SHORT : (double_press ? K_DOUBLE : K_LONG);
            check("pulse_onehot", npulse, 1);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_kind", kind, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", kind, e.kind);
                check("pulse_edge", cyc, e.cyc);
            end
        end
    end

    initial begin
        // Reset values
        step(2);
        check("rst_short", short_press, 0);
        check("rst_double", double_press, 0);
        check("rst_long", long_press, 0);
        check("rst_holding", holding, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step(2);

        // 1: short press
        p = cyc;
        btn_state = 1'b1;
        step(1);
        check("s1_busy_rise", busy, 1);
        step(4);
        btn_state = 1'b0;
        expect_pulse(K_SHORT, p + 5 + 1 + G);
        step(4);
        check("s1_busy_gap", busy, 1);
        step(G + 3);
        check("s1_busy_end", busy, 0);
        check("s1_pending", exp_q.size(), 0);

        // 2: double press
        p = cyc;
        btn_state = 1'b1;
        step(5);
        btn_state = 1'b0;
        step(3);
        btn_state = 1'b1;
        step(4);
        btn_state = 1'b0;
        expect_pulse(K_DOUBLE, p + 12 + 1);
        step(G + 4);
        check("s2_busy_end", busy, 0);
        check("s2_pending", exp_q.size(), 0);

        // 3: long press held 30 cycles
        p = cyc;
        btn_state = 1'b1;
        expect_pulse(K_LONG, p + 1 + L);
        step(L);
        check("s3_holding_before", holding, 0);
        step(1);
        check("s3_holding_set", holding, 1);
        step(9);
        check("s3_holding_late", holding, 1);
        btn_state = 1'b0;
        step(1);
        check("s3_holding_clear", holding, 0);
        check("s3_busy_clear", busy, 0);
        step(G + 4);
        check("s3_pending", exp_q.size(), 0);

        // 4a: release on the long-threshold edge -> short path
        p = cyc;
        btn_state = 1'b1;
        step(L);
        btn_state = 1'b0;
        expect_pulse(K_SHORT, p + L + 1 + G);
        step(1);
        check("s4a_holding", holding, 0);
        step(G + 4);
        check("s4a_pending", exp_q.size(), 0);

        // 4b: re-press on the gap-expiry edge -> double path
        p = cyc;
        btn_state = 1'b1;
        step(5);
        btn_state = 1'b0;
        step(G);
        btn_state = 1'b1;
        step(3);
        check("s4b_busy_press2", busy, 1);
        btn_state = 1'b0;
        expect_pulse(K_DOUBLE, p + 5 + G + 3 + 1);
        step(G + 4);
        check("s4b_busy_end", busy, 0);
        check("s4b_pending", exp_q.size(), 0);

        // 5: button held through reset
        rst_n = 1'b0;
        btn_state = 1'b1;
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(10);
            check("s5_busy_held", busy, 0);
        end
        btn_state = 1'b0;
        step(3);
        p = cyc;
        btn_state = 1'b1;
        step(5);
        btn_state = 1'b0;
        expect_pulse(K_SHORT, p + 5 + 1 + G);
        step(G + 4);
        check("s5_busy_end", busy, 0);
        check("s5_pending", exp_q.size(), 0);

        // 6: reset asserted during the gap
        btn_state = 1'b1;
        step(5);
        btn_state = 1'b0;
        step(3);
        check("s6_busy_gap", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_busy", busy, 0);
        check("s6_async_short", short_press, 0);
        check("s6_async_holding", holding, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(G + 6);
        check("s6_busy_after", busy, 0);
        check("s6_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/button_gesture_decoder.md
# button_gesture_decoder

Consumes the debounced button level from `button_debouncer` and classifies each interaction as a short press, double press or long press, each reported as a single-cycle pulse. It sits between the debouncer and the application control logic, so firmware-equivalent gesture timing runs in hardware on the 3 MHz fabric clock. It also provides a level flag while a long press is being held.

## Interface
- `LONG_CYCLES`, default 3_000_000: hold duration for a long press (1 s @ 3 MHz); must be ≥ 2.
- `GAP_CYCLES`, default 750_000: maximum release gap for a double press (250 ms @ 3 MHz); must be ≥ 2.
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_state`  in  1  debounced level, 1 = pressed; already synchronous to `clk`.
- `short_press`  out  1  one-cycle pulse: single press released, with no second press inside the gap.
- `double_press`  out  1  one-cycle pulse: second press released.
- `long_press`  out  1  one-cycle pulse: first press held for `LONG_CYCLES`.
- `holding`  out  1  level, high while in LONG_HELD.
- `busy`  out  1  level, high whenever the state is not IDLE.

## Operation
- Rise detect: `btn_prev` is registered from `btn_state`, and `rise = btn_state & ~btn_prev`. `btn_prev` resets to 1, so a button held through reset never starts a gesture.
- Counter width: `$clog2(max(LONG_CYCLES, GAP_CYCLES))` bits, unsigned.
- The counter clears on every state transition and increments once per cycle while in PRESS1 or WAIT_GAP. It never wraps.
- FSM states: IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD.
- IDLE: `rise` → PRESS1.
- PRESS1, evaluated in this priority order:
  - `btn_state`=0 → WAIT_GAP.
  - Otherwise, counter == `LONG_CYCLES`-1 → LONG_HELD with `long_press`.
  - Otherwise, stay and count.
- WAIT_GAP, evaluated in this priority order:
  - `btn_state`=1 → PRESS2.
  - Otherwise, counter == `GAP_CYCLES`-1 → IDLE with `short_press`.
  - Otherwise, stay and count.
- PRESS2: `btn_state`=0 → IDLE with `double_press`. Press duration is ignored, so a long second press still yields `double_press` on release.
- LONG_HELD: `btn_state`=0 → IDLE. No event is emitted on release.
- Simultaneous events:
  - A release on the exact cycle the long threshold is reached counts as a release (short path).
  - A re-press on the exact cycle the gap expires counts as a re-press (double path).
- At most one of the three pulse outputs is high in any cycle.

## Timing
- All outputs are registered. Reset values: `short_press`, `double_press`, `long_press`, `holding` and `busy` are 0; state is IDLE; counter is 0.
- The edge that samples `rise`=1 enters PRESS1 and clears the counter.
- `long_press` is high for exactly the one cycle beginning `LONG_CYCLES` edges after the PRESS1 entry edge, provided `btn_state` stayed 1 throughout. `holding` rises on that same edge.
- `short_press` is high for the one cycle beginning `GAP_CYCLES` edges after the WAIT_GAP entry edge.
- `double_press` is high for the one cycle after the edge that samples `btn_state`=0 in PRESS2.
- `busy` rises on the edge entering PRESS1 and falls on the edge returning to IDLE.
- Asserting `rst_n` mid-gesture aborts it immediately: no pulse is emitted, state returns to IDLE and `btn_prev` is 1. After deassertion, a new gesture starts only after `btn_state` has been seen 0 and then 1.

## Structure
- Shared package `button_pkg` holds:
  - `typedef enum logic [2:0] gesture_state_t` {IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD};
  - default constants `LONG_CYCLES_3MHZ` and `GAP_CYCLES_3MHZ`.
  - `button_debouncer` will import the same package for its `DEBOUNCE_CYCLES` default.
- Single module, with no sub-module. The counter and FSM are inline, using one `always_ff` for state, counter and outputs.

## Test plan
All scenarios use `LONG_CYCLES`=20 and `GAP_CYCLES`=8.
- Press for 5 cycles, release, stay idle → one `short_press` pulse 8 cycles after release; no other pulse; `busy` low afterwards.
- Press 5, release 3, press 4, release → one `double_press` the cycle after the second release; `short_press` never fires.
- Hold for 30 cycles → `long_press` pulses exactly 20 cycles after PRESS1 entry; `holding` is high from that edge until release; no pulse on release.
- Release exactly on cycle 20 of PRESS1 → no `long_press`, and `short_press` follows 8 cycles later. Re-press exactly on gap cycle 8 → the double path is taken.
- `btn_state`=1 while in reset, then `rst_n` deasserts with the button still held for 40 cycles → no event and `busy` stays 0. Release, then press 5 cycles → normal `short_press`.
- Assert `rst_n`=0 during WAIT_GAP → all outputs go to 0 asynchronously; no `short_press` after reset is deasserted.
